// File: rtl/huff_frame_ctrl.sv
// rtl/huff_frame_ctrl.sv - symbol FIFO and framing FSM feeding a Huffman encoder
// Optional feature macro HUFF_PAD_EN: pad a short message by repeating its last symbol.
module huff_frame_ctrl #(
    parameter int BIT_WIDTH  = 7,
    parameter int FRAME_LEN  = 100,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 4095
) (
    input  logic               clock,
    input  logic               rst,
    input  logic [BIT_WIDTH:0] s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [BIT_WIDTH:0] enc_data,
    output logic               enc_enable,
    output logic               enc_rst_n,
    input  logic               enc_done,
    output logic               busy,
    output logic [7:0]         frame_cnt,
    output logic               err_timeout
);
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW = $clog2(FRAME_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);
`ifdef HUFF_PAD_EN
    localparam int EW = BIT_WIDTH + 2;
`else
    localparam int EW = BIT_WIDTH + 1;
`endif

    typedef enum logic [1:0] {IDLE, CLEAR, FEED, WAIT_DONE} state_t;
    state_t state, next_state;

    logic [EW-1:0]      mem [FIFO_DEPTH];
    logic [EW-1:0]      wr_entry, head;
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic               full, empty, push, pop, pad_issue, pad_mode, last_feed;
    logic               clr_cnt;
    logic [FCW-1:0]     feed_cnt;
    logic [TCW-1:0]     to_cnt;
    logic               pipe_vld;
    logic [BIT_WIDTH:0] pipe_data;

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign s_ready   = !full;
    assign push      = s_valid && !full;
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE);
    assign last_feed = (feed_cnt == FCW'(FRAME_LEN - 1));

`ifdef HUFF_PAD_EN
    assign wr_entry = {s_last, s_data};

    // Once the message's last symbol leaves the FIFO early, keep re-issuing it.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst)
            pad_mode <= 1'b0;
        else if (state == CLEAR)
            pad_mode <= 1'b0;
        else if (pop && head[EW-1] && !last_feed)
            pad_mode <= 1'b1;
    end
`else
    logic unused_last;
    assign wr_entry    = s_data;
    assign pad_mode    = 1'b0;
    assign unused_last = s_last;
`endif

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        pad_issue  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty)
                    next_state = CLEAR;
            end
            CLEAR: begin
                if (clr_cnt)
                    next_state = FEED;
            end
            FEED: begin
                if (pad_mode) begin
                    pad_issue = 1'b1;
                    if (last_feed)
                        next_state = WAIT_DONE;
                end else if (!empty) begin
                    pop = 1'b1;
                    if (last_feed)
                        next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (enc_done || to_cnt == TCW'(TIMEOUT - 1))
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            clr_cnt     <= 1'b0;
            feed_cnt    <= '0;
            to_cnt      <= '0;
            frame_cnt   <= '0;
            err_timeout <= 1'b0;
        end else begin
            clr_cnt <= (state == CLEAR) ? !clr_cnt : 1'b0;
            if (state == CLEAR)
                feed_cnt <= '0;
            else if (pop || pad_issue)
                feed_cnt <= feed_cnt + 1'b1;
            to_cnt <= (state == WAIT_DONE) ? to_cnt + 1'b1 : '0;
            if (state == WAIT_DONE && enc_done)
                frame_cnt <= frame_cnt + 1'b1;
            else if (state == WAIT_DONE && to_cnt == TCW'(TIMEOUT - 1))
                err_timeout <= 1'b1;
        end
    end

    // Popped head passes through one stage so a fresh push never reaches enc_data within two edges.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            pipe_vld   <= 1'b0;
            pipe_data  <= '0;
            enc_enable <= 1'b0;
            enc_data   <= '0;
            enc_rst_n  <= 1'b0;
        end else begin
            pipe_vld <= pop || pad_issue;
            if (pop)
                pipe_data <= head[BIT_WIDTH:0];
            enc_enable <= pipe_vld;
            if (pipe_vld)
                enc_data <= pipe_data;
            enc_rst_n <= (next_state != CLEAR);
        end
    end
endmodule

// File: tb/tb_huff_frame_ctrl.sv
// tb/tb_huff_frame_ctrl.sv - scoreboard bench for huff_frame_ctrl
module tb_huff_frame_ctrl;
    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic [7:0] enc_data;
    logic       enc_enable;
    logic       enc_rst_n;
    logic       enc_done = 1'b0;
    logic       busy;
    logic [7:0] frame_cnt;
    logic       err_timeout;

    huff_frame_ctrl #(
        .BIT_WIDTH(7), .FRAME_LEN(4), .FIFO_DEPTH(4), .TIMEOUT(8)
    ) dut (
        .clock(clock), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .enc_data(enc_data), .enc_enable(enc_enable),
        .enc_rst_n(enc_rst_n), .enc_done(enc_done), .busy(busy),
        .frame_cnt(frame_cnt), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    int         en_count = 0;
    int         en_runs = 0;
    int         low_run = 0;
    int         last_low = 0;
    int         low_events = 0;
    logic       prev_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (rst) begin
            if (enc_enable) begin
                en_count++;
                if (!prev_en)
                    en_runs++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL enc_data_unexpected actual=0x%0h required=none", enc_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (enc_data !== mon_exp) begin
                        failures++;
                        $display("FAIL enc_data actual=0x%0h required=0x%0h", enc_data, mon_exp);
                    end
                end
            end
            prev_en = enc_enable;
            if (!enc_rst_n)
                low_run++;
            else if (low_run != 0) begin
                last_low = low_run;
                low_events++;
                low_run = 0;
            end
        end else begin
            prev_en = 1'b0;
            low_run = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        enc_done = 1'b0;
        #1;
        check("rst_enc_enable", enc_enable, 0);
        check("rst_enc_data", enc_data, 0);
        check("rst_enc_rst_n", enc_rst_n, 0);
        check("rst_busy", busy, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err_timeout", err_timeout, 0);
        step(2);
        exp_q.delete();
        rst = 1'b1;
        step(1);
        check("enc_rst_n_after_reset", enc_rst_n, 1);
        step(1);
    endtask

    task automatic push(input logic [7:0] d, input logic l, output int waited);
        waited = 0;
        s_data = d;
        s_last = l;
        s_valid = 1'b1;
        while (!s_ready && waited < 50) begin
            step(1);
            waited++;
        end
        if (!s_ready) begin
            check("push_accept", s_ready, 1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        s_valid = 1'b0;
        s_last = 1'b0;
        exp_q.push_back(d);
    endtask

    task automatic push4(input logic [7:0] b);
        int w;
        for (int i = 0; i < 4; i++) push(8'(b + i), 1'b0, w);
    endtask

    task automatic wait_en(input int target);
        int n;
        n = 0;
        while (en_count < target && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("enable_count", en_count, target);
    endtask

    task automatic pulse_done();
        enc_done = 1'b1;
        step(1);
        enc_done = 1'b0;
    endtask

    initial begin
        int w, n, ev0, base, runs0;
        do_reset();
        pulse_done();
        check("done_ignored_in_idle", frame_cnt, 0);

        ev0 = low_events; base = en_count; runs0 = en_runs;
        for (int i = 1; i <= 4; i++) push(8'(8'h11 * i), 1'b0, w);
        wait_en(base + 4);
        check("t1_clear_events", low_events - ev0, 1);
        check("t1_clear_len", last_low, 2);
        check("t1_single_burst", en_runs - runs0, 1);
        check("t1_queue_drained", exp_q.size(), 0);
        pulse_done();
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_busy", busy, 0);

        do_reset();
        base = en_count;
        push4(8'hA1);
        check("t2_full_ready", s_ready, 0);
        push(8'hA5, 1'b0, w);
        check("t2_held_cycles", w, 1);
        wait_en(base + 4);
        pulse_done();
        push(8'hA6, 1'b0, w);
        push(8'hA7, 1'b0, w);
        push(8'hA8, 1'b0, w);
        wait_en(base + 8);
        pulse_done();
        check("t2_frame_cnt", frame_cnt, 2);

        do_reset();
        base = en_count; runs0 = en_runs;
        push(8'hC1, 1'b0, w);
        push(8'hC2, 1'b0, w);
        wait_en(base + 2);
        step(3);
        push(8'hC3, 1'b0, w);
        push(8'hC4, 1'b0, w);
        wait_en(base + 4);
        step(2);
        check("t3_enables", en_count - base, 4);
        check("t3_bursts", en_runs - runs0, 2);
        check("t3_waiting", busy, 1);
        pulse_done();
        check("t3_frame_cnt", frame_cnt, 1);

        do_reset();
        base = en_count;
        push4(8'hD1);
        wait_en(base + 4);
        step(4);
        check("t4_no_early_timeout", err_timeout, 0);
        check("t4_still_waiting", busy, 1);
        n = 0;
        while (busy && n < 12) begin
            step(1);
            n++;
        end
        check("t4_idle", busy, 0);
        check("t4_err_timeout", err_timeout, 1);
        check("t4_frame_cnt", frame_cnt, 0);
        push4(8'hE1);
        wait_en(base + 8);
        pulse_done();
        check("t4_next_frame_cnt", frame_cnt, 1);
        check("t4_err_sticky", err_timeout, 1);

        do_reset();
        base = en_count;
        push4(8'hF1);
        wait_en(base + 2);
        do_reset();
        base = en_count;
        step(5);
        check("t5_fifo_empty", busy, 0);
        check("t5_no_enables", en_count - base, 0);
        ev0 = low_events;
        push4(8'h71);
        wait_en(base + 4);
        check("t5_clear_events", low_events - ev0, 1);
        check("t5_clear_len", last_low, 2);
        pulse_done();
        check("t5_frame_cnt", frame_cnt, 1);

`ifdef HUFF_PAD_EN
        do_reset();
        base = en_count;
        push(8'h5A, 1'b0, w);
        push(8'h6B, 1'b1, w);
        exp_q.push_back(8'h6B);
        exp_q.push_back(8'h6B);
        wait_en(base + 4);
        check("t6_queue_drained", exp_q.size(), 0);
        pulse_done();
        check("t6_frame_cnt", frame_cnt, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/huff_frame_ctrl.md
HUFF_FRAME_CTRL -- requirements
Module: huff_frame_ctrl

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 7: symbol MSB index; the symbol width is BIT_WIDTH+1 bits.
REQ-002 SHALL have parameter FRAME_LEN, default 100: number of symbols fed to the encoder per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, a power of two: depth of the input buffer.
REQ-004 SHALL have parameter TIMEOUT, default 4095: maximum WAIT_DONE cycles.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all flops sample on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port s_data, input, BIT_WIDTH+1 bits: upstream symbol.
REQ-008 SHALL have port s_valid, input, 1 bit: upstream symbol valid.
REQ-009 SHALL have port s_last, input, 1 bit: last symbol of the upstream message (used only with HUFF_PAD_EN).
REQ-010 SHALL have port s_ready, output, 1 bit: buffer can accept a symbol.
REQ-011 SHALL have port enc_data, output, BIT_WIDTH+1 bits: symbol to the encoder data_in.
REQ-012 SHALL have port enc_enable, output, 1 bit: to the encoder data_enable.
REQ-013 SHALL have port enc_rst_n, output, 1 bit: active-low encoder restart.
REQ-014 SHALL have port enc_done, input, 1 bit: single-cycle pulse from the encoder when its header and code emission completes.
REQ-015 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 SHALL have port frame_cnt, output, 8 bits: completed frames, wrapping at 255 to 0.
REQ-017 SHALL have port err_timeout, output, 1 bit: sticky timeout flag.

Function
REQ-018 SHALL buffer symbols in a FIFO of FIFO_DEPTH entries; s_ready = !full; a push occurs when s_valid && s_ready.
REQ-019 SHALL allow a simultaneous push and pop in one cycle; the occupancy is then unchanged; there is no bypass when the FIFO is empty.
REQ-020 SHALL implement the FSM states IDLE, CLEAR, FEED and WAIT_DONE.
REQ-021 IDLE: SHALL go to CLEAR when the FIFO is non-empty.
REQ-022 CLEAR: SHALL hold enc_rst_n = 0 for exactly 2 cycles, clear the feed counter, then go to FEED.
REQ-023 FEED: each cycle the FIFO is non-empty, SHALL pop the head and, on the next cycle, drive enc_data = head with enc_enable = 1.
REQ-024 FEED: when the FIFO is empty, SHALL drive enc_enable = 0 and hold enc_data; the frame does not abort.
REQ-025 SHALL register enc_data and enc_enable; a symbol pushed on edge t SHALL appear on enc_data no earlier than after edge t+2.
REQ-026 SHALL count the feed counter (width clog2(FRAME_LEN+1)) up by 1 per pop; after the FRAME_LEN-th pop, SHALL go to WAIT_DONE with no further pops.
REQ-027 WAIT_DONE: on enc_done = 1, SHALL increment frame_cnt and go to IDLE.
REQ-028 WAIT_DONE: if enc_done is not seen within TIMEOUT cycles, SHALL set err_timeout = 1 and go to IDLE, with frame_cnt not incremented.
REQ-029 SHALL ignore enc_done in every state other than WAIT_DONE.
REQ-030 SHALL hold enc_rst_n = 1 in every state except CLEAR.

Reset
REQ-031 While rst = 0: FSM in IDLE, FIFO empty, s_ready = 1, enc_enable = 0, enc_data = 0, enc_rst_n = 0, busy = 0, frame_cnt = 0, err_timeout = 0, all counters 0.
REQ-032 SHALL drive enc_rst_n to 1 on the first rising edge after rst deasserts.
REQ-033 An assertion of rst mid-frame SHALL discard all buffered symbols and the partial frame immediately.
REQ-034 err_timeout SHALL be cleared only by rst.

Configuration
REQ-035 With the macro HUFF_PAD_EN defined: when s_last is popped before FRAME_LEN symbols have been fed, SHALL feed the last symbol repeatedly, one per cycle with enc_enable = 1, without popping, until FRAME_LEN is reached.
REQ-036 Without HUFF_PAD_EN: SHALL ignore s_last; every frame consists of exactly FRAME_LEN popped symbols.

Verification (bench: BIT_WIDTH=7, FRAME_LEN=4, FIFO_DEPTH=4, TIMEOUT=8)
REQ-037 Push 0x11,0x22,0x33,0x44 back-to-back -> enc_rst_n low 2 cycles; enc_enable high 4 consecutive cycles with 0x11..0x44 in order; enc_done pulse -> frame_cnt = 1, busy = 0.
REQ-038 Push 5 symbols with no pops while in CLEAR -> s_ready = 0 after the 4th push; the 5th is held upstream until the first pop.
REQ-039 Feed 2 symbols, then stall upstream for 3 cycles, then 2 more -> enc_enable low during the stall; exactly 4 enables total; state is WAIT_DONE.
REQ-040 No enc_done for 8 cycles in WAIT_DONE -> err_timeout = 1, frame_cnt unchanged, FSM in IDLE; a later frame completes normally with err_timeout still 1.
REQ-041 HUFF_PAD_EN defined, push 0x5A, then 0x6B with s_last = 1 -> enc_data sequence 0x5A, 0x6B, 0x6B, 0x6B.
REQ-042 Assert rst after the 2nd enable of a frame -> all outputs at their REQ-031 values; the FIFO is empty; a following frame starts with a CLEAR.
